nn_result_reader: RTL and testbench

NN_RESULT_READER -- requirements
Module: nn_result_reader

---
 rtl/nn_result_reader.sv | 145 ++++++++++++++
 tb/tb_nn_result_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_result_reader.sv
// nn_result_reader: after the inference core signals completion, reads the
// output-layer activations from the result RAM one by one, streams them out
// on a valid/ready port and reports the index/value of the largest one.
//
// Handshake: out_data/out_last are presented with out_valid and held stable
// until out_valid && out_ready is seen on a rising edge (the transfer); the
// source never withdraws out_valid before a transfer.
module nn_result_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_done,
    input  logic [ADDR_W-1:0] n_out,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W-1:0] argmax_idx,
    output logic [DATA_W-1:0] argmax_val,
    output logic              argmax_valid,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_CAPT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_cnt;       // element count of the running job
    logic [ADDR_W-1:0] r_i;         // current element index
    logic [DATA_W-1:0] r_max;       // running maximum (signed)
    logic [ADDR_W-1:0] r_idx;       // index of running maximum
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_amax_idx;  // last published result
    logic [DATA_W-1:0] r_amax_val;
    logic              w_last;

    assign w_last = (r_i == (r_cnt - ADDR_ONE));

    // State register; reset always returns to IDLE, abandoning any job.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: one read request, one capture, then hold in SEND
    // until the element is accepted downstream.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (core_done) begin
                    w_next = (n_out != '0) ? S_REQ : S_DONE;
                end
            end
            S_REQ:  w_next = S_CAPT;
            S_CAPT: w_next = S_SEND;
            S_SEND: begin
                if (out_ready) begin
                    w_next = w_last ? S_DONE : S_REQ;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Job datapath: latch the job on start, capture RAM data and track the
    // maximum, advance the index on each accepted element, publish at DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_i        <= '0;
            r_max      <= '0;
            r_idx      <= '0;
            r_out_data <= '0;
            r_amax_idx <= '0;
            r_amax_val <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (core_done) begin
                        r_cnt <= n_out;
                        r_max <= MOST_NEG;
                        r_idx <= '0;
                        // An empty job never reads, so the address output
                        // keeps its previous value in that case.
                        if (n_out != '0) begin
                            r_i <= '0;
                        end
                    end
                end
                S_CAPT: begin
                    r_out_data <= ram_rdata;
                    // Strictly greater: ties keep the lower index.
                    if ($signed(ram_rdata) > $signed(r_max)) begin
                        r_max <= ram_rdata;
                        r_idx <= r_i;
                    end
                end
                S_SEND: begin
                    if (out_ready && !w_last) begin
                        r_i <= r_i + ADDR_ONE;
                    end
                end
                S_DONE: begin
                    r_amax_idx <= r_idx;
                    r_amax_val <= r_max;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign ram_rd_en    = (r_state == S_REQ);
    assign ram_addr     = r_i;
    assign out_data     = r_out_data;
    assign out_valid    = (r_state == S_SEND);
    assign out_last     = (r_state == S_SEND) && w_last;
    assign argmax_valid = (r_state == S_DONE);
    // During DONE the fresh result is shown; afterwards the published copy.
    assign argmax_idx   = (r_state == S_DONE) ? r_idx : r_amax_idx;
    assign argmax_val   = (r_state == S_DONE) ? r_max : r_amax_val;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_nn_result_reader.sv
// Bench for nn_result_reader: directed jobs, a RAM model, and a negedge
// monitor that checks stream data, argmax results, latency, read addresses,
// backpressure stability and reset values against expected queues.
module tb_nn_result_reader;

  localparam int DW = 16;
  localparam int AW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          core_done = 1'b0;
  logic [AW-1:0] n_out = '0;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic [AW-1:0] argmax_idx;
  logic [DW-1:0] argmax_val;
  logic          argmax_valid;
  logic          busy;
  logic [2:0]    dbg_state;

  nn_result_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .core_done(core_done), .n_out(n_out),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .argmax_idx(argmax_idx), .argmax_val(argmax_val),
    .argmax_valid(argmax_valid), .busy(busy), .dbg_state(dbg_state)
  );

  // Result RAM model: data valid one cycle after the read strobe.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [DW:0]         exp_q[$];   // {last, data}
  logic [8+AW+DW-1:0]  arg_q[$];   // {reads, idx, val}
  logic [3:0]          lat_q[$];   // cycles from accept to first output
  int n_checks = 0;
  int n_fail   = 0;
  logic stim_done = 1'b0;
  int   ready_mode = 0;            // 0: always ready, 1: 1-of-3, 2: held low
  int   rc = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = (rc % 3 == 0);
      default: out_ready = 1'b0;
    endcase
    rc++;
  endtask

  task automatic start_job(input int n);
    logic signed [DW-1:0] mx;
    int mi;
    mx = 16'sh8000;
    mi = 0;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({(k == n - 1), mem[k]});
      if ($signed(mem[k]) > mx) begin
        mx = mem[k];
        mi = k;
      end
    end
    arg_q.push_back({8'(n), AW'(mi), mx});
    lat_q.push_back((n == 0) ? 4'd1 : 4'd3);
    n_out = AW'(n);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    n_out = AW'($urandom_range(0, 63));   // must not disturb the job
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000 && busy; k++) tick();
    tick();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // three elements, always ready
    mem[0] = 16'h0100; mem[1] = 16'hFF00; mem[2] = 16'h0200;
    ready_mode = 0;
    start_job(3);
    wait_idle();

    // ties under backpressure: lowest index wins
    mem[0] = 16'h0050; mem[1] = 16'h0050; mem[2] = 16'h0010; mem[3] = 16'h0050;
    ready_mode = 1;
    start_job(4);
    wait_idle();
    ready_mode = 0;

    // all negative: signed compare
    mem[0] = 16'h8001; mem[1] = 16'hFFFF;
    start_job(2);
    wait_idle();

    // empty job
    start_job(0);
    wait_idle();

    // largest job, mixed values
    for (int k = 0; k < 64; k++) mem[k] = 16'($urandom_range(0, 65535));
    start_job(63);
    wait_idle();

    // ignored second start, then reset in the SEND of element index 2
    mem[0] = 16'h0010; mem[1] = 16'h0020; mem[2] = 16'h0030;
    mem[3] = 16'h0040; mem[4] = 16'h0050;
    exp_q.push_back({1'b0, 16'h0010});
    exp_q.push_back({1'b0, 16'h0020});
    lat_q.push_back(4'd3);
    n_out = 6'd5;
    core_done = 1'b1;
    tick();                      // accepted; now cycle 1 (REQ 0)
    core_done = 1'b0;
    repeat (4) tick();           // cycle 5 (CAPT 1)
    n_out = 6'd2;
    core_done = 1'b1;
    tick();                      // cycle 6 (SEND 1)
    core_done = 1'b0;
    repeat (2) tick();           // cycle 8 (CAPT 2)
    ready_mode = 2;
    tick();                      // cycle 9 (SEND 2), stalled
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready_mode = 0;
    tick();

    // normal job after the abort
    start_job(1);
    wait_idle();

    stim_done = 1'b1;
  end

  // ---------------- monitor ----------------
  initial begin
    logic          prev_rst;
    logic          stall;
    logic [DW:0]   stall_v;
    logic          lat_run;
    int            lat;
    int            rd_cnt;
    int            busy_cyc;
    logic [DW:0]   e;
    logic [8+AW+DW-1:0] a;
    logic [3:0]    el;
    prev_rst = 1'b0; stall = 1'b0; stall_v = '0; lat_run = 1'b0;
    lat = 0; rd_cnt = 0; busy_cyc = 0;
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        n_checks++;
        if ({busy, ram_rd_en, out_valid, out_last, argmax_valid,
             ram_addr, out_data, argmax_idx, argmax_val} != '0) begin
          n_fail++;
          $display("FAIL reset_outputs: busy=%0b rd_en=%0b valid=%0b last=%0b amv=%0b addr=%0d data=%h idx=%0d val=%h, required all zero",
                   busy, ram_rd_en, out_valid, out_last, argmax_valid,
                   ram_addr, out_data, argmax_idx, argmax_val);
        end
      end
      if (rst) begin
        stall = 1'b0; lat_run = 1'b0; rd_cnt = 0; busy_cyc = 0;
      end else begin
        if (lat_run) begin
          lat++;
          if (out_valid || argmax_valid) begin
            lat_run = 1'b0;
            n_checks++;
            if (lat_q.size() == 0) begin
              n_fail++;
              $display("FAIL latency: output at %0d cycles with no job expected", lat);
            end else begin
              el = lat_q.pop_front();
              if (lat != int'(el)) begin
                n_fail++;
                $display("FAIL latency: got %0d cycles, required %0d", lat, el);
              end
            end
          end
        end
        if (!busy && core_done) begin
          lat_run = 1'b1; lat = 0; rd_cnt = 0;
        end
        if (ram_rd_en) begin
          n_checks++;
          if (ram_addr != AW'(rd_cnt)) begin
            n_fail++;
            $display("FAIL read_addr: got %0d, required %0d", ram_addr, rd_cnt);
          end
          rd_cnt++;
        end
        if (stall) begin
          n_checks++;
          if (!out_valid || {out_last, out_data} != stall_v) begin
            n_fail++;
            $display("FAIL hold_under_backpressure: valid=%0b last/data=%h, required valid=1 last/data=%h",
                     out_valid, {out_last, out_data}, stall_v);
          end
        end
        stall   = out_valid && !out_ready;
        stall_v = {out_last, out_data};
        if (out_valid && out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL stream: unexpected transfer last/data=%h", {out_last, out_data});
          end else begin
            e = exp_q.pop_front();
            if ({out_last, out_data} != e) begin
              n_fail++;
              $display("FAIL stream: got last/data=%h, required %h", {out_last, out_data}, e);
            end
          end
        end
        if (argmax_valid) begin
          n_checks++;
          if (arg_q.size() == 0) begin
            n_fail++;
            $display("FAIL argmax: unexpected pulse idx=%0d val=%h", argmax_idx, argmax_val);
          end else begin
            a = arg_q.pop_front();
            if ({8'(rd_cnt), argmax_idx, argmax_val} != a) begin
              n_fail++;
              $display("FAIL argmax: got reads=%0d idx=%0d val=%h, required reads=%0d idx=%0d val=%h",
                       rd_cnt, argmax_idx, argmax_val, a[8+AW+DW-1 -: 8], a[AW+DW-1 -: AW], a[DW-1:0]);
            end
          end
        end
        busy_cyc = busy ? busy_cyc + 1 : 0;
        if (busy_cyc == 400) begin
          n_checks++;
          n_fail++;
          $display("FAIL busy_timeout: busy for 400 cycles, required job completion");
        end
      end
      prev_rst = rst;
      if (stim_done) begin
        n_checks++;
        if (exp_q.size() != 0 || arg_q.size() != 0 || lat_q.size() != 0) begin
          n_fail++;
          $display("FAIL leftover_expected: stream=%0d argmax=%0d latency=%0d, required 0 0 0",
                   exp_q.size(), arg_q.size(), lat_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  // Overall time limit so the run always ends.
  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "time limit reached");
  end

endmodule
